// File: rtl/lu_pkg.sv
// Shared types for the logic unit pipe: operation codes and the flag half of a FIFO entry.
// An entry is {result[WIDTH-1:0], lu_flags_t} so the flags always sit in the two LSBs.
package lu_pkg;

  localparam int LU_OP_W = 3;

  typedef enum logic [LU_OP_W-1:0] {
    LU_NAND = 3'd0,
    LU_AND  = 3'd1,
    LU_OR   = 3'd2,
    LU_NOR  = 3'd3,
    LU_XOR  = 3'd4,
    LU_XNOR = 3'd5,
    LU_NOTA = 3'd6,
    LU_PASS = 3'd7
  } lu_op_t;

  typedef struct packed {
    logic zero;
    logic parity;
  } lu_flags_t;

  localparam int LU_FLAGS_W = $bits(lu_flags_t);

endpackage

// File: rtl/lu_result_fifo.sv
// Synchronous in-order FIFO; head is registered storage, visible the cycle after a push into empty.
// Backpressure: full blocks pushes (no pass-through on a same-cycle pop); clear flushes pointers and count.
module lu_result_fifo #(
  parameter int DW    = 10,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic [DW-1:0] push_dat,
  input  logic          pop,
  output logic [DW-1:0] head_dat,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_dat = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Bitwise logic unit with chain accumulator; result+flags land in an output FIFO one edge after accept.
// Backpressure: in_ready drops when the FIFO is full, during clear, and while in reset.
module logic_unit_pipe
  import lu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LU_OP_W-1:0] op,
  input  logic               chain,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               parity
);

  localparam int ENTRY_W = WIDTH + LU_FLAGS_W;

  lu_op_t             op_e;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   res;
  lu_flags_t          res_flags;
  lu_flags_t          head_flags;
  logic [ENTRY_W-1:0] push_dat;
  logic [ENTRY_W-1:0] head_dat;
  logic               fifo_full, fifo_empty;
  logic               push, pop;

  assign op_e = lu_op_t'(op);
  assign op_a = chain ? acc_q : a;

  always_comb begin
    res = '0;
    unique case (op_e)
      LU_NAND: res = ~(op_a & b);
      LU_AND:  res = op_a & b;
      LU_OR:   res = op_a | b;
      LU_NOR:  res = ~(op_a | b);
      LU_XOR:  res = op_a ^ b;
      LU_XNOR: res = ~(op_a ^ b);
      LU_NOTA: res = ~op_a;
      LU_PASS: res = op_a;
      default: res = '0;
    endcase
  end

  assign res_flags.zero   = (res == '0);
  assign res_flags.parity = ^res;
  assign push_dat         = {res, res_flags};

  // rst_n gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = rst_n && !fifo_full && !clear;
  assign push      = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready && !clear;

  lu_result_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign {result, head_flags} = head_dat;
  assign zero   = head_flags.zero;
  assign parity = head_flags.parity;

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (push) begin
      acc_d = res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: doc/logic_unit_pipe.md
# logic_unit_pipe

Parametrised, registered successor to the fixed 8-bit bitwise NAND component. It applies one of eight bitwise operations to two WIDTH-bit operands per transaction, with an optional chain mode that substitutes the previous result for operand A. Results, zero and parity flags are buffered in a DEPTH-entry output FIFO behind valid/ready handshakes. It sits between the operand-select logic and the result writeback of the datapath.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 4, output FIFO entries (power of 2, ≥2)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous flush of FIFO and accumulator
- in_valid  in  1  transaction offered
- in_ready  out  1  transaction accepted when in_valid && in_ready
- op  in  3  operation code (lu_op_t)
- chain  in  1  1: operand A := accumulator
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- out_valid  out  1  FIFO head valid
- out_ready  in  1  consumer takes head when out_valid && out_ready
- result  out  WIDTH  FIFO head result
- zero  out  1  head result == 0
- parity  out  1  XOR-reduction of head result

## Operation
- Op codes: 0 NAND, 1 AND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT A, 7 PASS A; all bitwise, no carries, result width = WIDTH.
- Effective A = chain ? acc : a; acc is a WIDTH-bit register.
- On accept: compute result combinationally, push {result, zero, parity} into FIFO, load acc ← result.
- in_ready = !full && !clear. No pass-through when full: a same-cycle pop does not free a slot for a push.
- Pop on out_valid && out_ready; FIFO is strictly in order.
- Simultaneous push and pop (not full, not empty): count unchanged, both take effect.
- clear=1: FIFO count → 0, acc → 0 at the edge; any in_valid that cycle is not accepted (in_ready=0); a pop that cycle is irrelevant.
- Chain immediately after reset or clear uses acc = 0.
- Undriven op values do not exist; all 8 codes are legal.

## Timing
- Reset (rst_n=0, asynchronous): out_valid=0, in_ready=0 while asserted, FIFO count=0, pointers=0, acc=0; result/zero/parity=0 (head storage cleared).
- in_ready rises combinationally after reset deassertion (first edge with rst_n=1 can accept).
- Latency: accept at edge N → out_valid=1 after edge N if FIFO was empty; head outputs are registered FIFO storage, not combinational from inputs.
- Throughput: one transaction per cycle when out_ready held high.
- Chain back-to-back: transaction at N+1 sees acc from N (no bubble).
- Reset mid-operation: all buffered entries discarded; no partial output.

## Structure
- Package lu_pkg: lu_op_t enum (3 bits, codes above), LU_OP_W constant, entry struct layout {result, zero, parity}.
- Sub-module lu_result_fifo: sync FIFO, WIDTH+2 data bits, DEPTH entries, push/pop/clear, full/empty, async active-low reset.
- Top level holds the op decoder, chain mux, accumulator and flag generation.

## Test plan
- WIDTH=8: NAND a=0xF0 b=0xCC, out_ready=1 → one cycle later result=0x3F, zero=0, parity=0.
- DEPTH=4, out_ready=0, five back-to-back pushes → in_ready low after 4th; 5th held until the first pop; drain order matches issue order.
- AND a=0xFF b=0x0F then chain XOR b=0x0F → results 0x0F, then 0x00 with zero=1, parity=0.
- rst_n pulsed low with 3 entries queued → out_valid=0 immediately; after release, chain OR b=0x81 → result 0x81, parity=0.
- clear with in_valid=1 and 2 entries queued → in_ready=0 that cycle, next cycle out_valid=0, input not captured, next chain uses acc=0.
- Count=2, push and pop same cycle → count stays 2; output sequence correct; sweep all 8 ops against a bitwise model with random operands.
